// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4:1 mux path among four requesters,
// capturing the winner's word into a single valid/ready output slot.
module mux4_rr_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] i1,
    input  logic [DW-1:0] i2,
    input  logic [DW-1:0] i3,
    input  logic [DW-1:0] i4,
    output logic [3:0]    gnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nxt;
    logic [1:0] ptr, w;
    logic found, load;
    logic [DW-1:0] sel_data;
    // Scan downward so the index closest to ptr is the last one assigned and wins.
    always_comb begin
        w = ptr;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                w = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end
    assign load = rst_n && found && (state == EMPTY || out_ready);
    assign gnt = load ? 4'b0001 << w : 4'b0000;
    assign sel_data = w == 2'd0 ? i1 : w == 2'd1 ? i2 : w == 2'd2 ? i3 : i4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = load ? FULL : (state == FULL && out_ready) ? EMPTY : state;
    end
    always_comb begin
        out_valid = state == FULL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= 2'd0;
            ptr      <= 2'd0;
        end else if (load) begin
            out_data <= sel_data;
            out_src  <= w;
            ptr      <= w + 2'd1;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: vector table plus reference-model soak for the round-robin mux arbiter.
module tb_mux4_rr_arbiter;
    logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [3:0] req = '0, i1 = '0, i2 = '0, i3 = '0, i4 = '0;
    logic [3:0] gnt, out_data;
    logic out_valid;
    logic [1:0] out_src;
    int tests = 0, fails = 0;

    typedef struct {
        logic [3:0] req, a, b, c, d;
        logic rdy;
        logic [3:0] gnt;
        logic v;
        logic [3:0] dat;
        logic [1:0] src;
    } vec_t;
    typedef struct {
        logic v;
        logic [3:0] d;
        logic [1:0] s;
    } exp_t;
    exp_t sb[$];
    vec_t tv[19];

    mux4_rr_arbiter #(.DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [3:0] pend, exp_g;
        logic [3:0] pdata[4];
        int waitc[4];
        logic m_v, can, fnd;
        int m_ptr, w, j;

        tv[0]  = '{4'b0100, 4'h1, 4'h2, 4'hA, 4'h4, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
        tv[1]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        tv[2]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        tv[3]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        tv[4]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        tv[5]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        tv[6]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        tv[7]  = '{4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        for (int i = 8; i < 13; i++)
            tv[i] = '{4'b1101, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1};
        tv[13] = '{4'b1101, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        tv[14] = '{4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd2};
        tv[15] = '{4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b0, 4'h3, 2'd2};
        tv[16] = '{4'b0001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0001, 1'b1, 4'h1, 2'd0};
        tv[17] = '{4'b0001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
        tv[18] = '{4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};

        // Reset held for 3 edges with requests pending: nothing may be granted.
        req = 4'b1111;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_gnt", gnt, 0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            req = tv[i].req; i1 = tv[i].a; i2 = tv[i].b; i3 = tv[i].c; i4 = tv[i].d;
            out_ready = tv[i].rdy;
            sb.push_back('{tv[i].v, tv[i].dat, tv[i].src});
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), gnt, tv[i].gnt);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("vec%0d_valid", i), out_valid, e.v);
            chk($sformatf("vec%0d_data", i), out_data, e.d);
            chk($sformatf("vec%0d_src", i), out_src, e.s);
        end

        // Async reset while FULL and stalled.
        req = 4'b0001; i1 = 4'h7; out_ready = 1'b1;
        @(negedge clk);
        chk("ar_load_gnt", gnt, 4'b0001);
        @(posedge clk);
        #1;
        chk("ar_load_data", out_data, 4'h7);
        chk("ar_load_valid", out_valid, 1);
        req = 4'b1111; out_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_src", out_src, 0);
        chk("ar_gnt", gnt, 0);
        @(posedge clk);
        #1;
        chk("ar_gnt_held", gnt, 0);
        chk("ar_valid_held", out_valid, 0);
        rst_n = 1'b1;
        req = 4'b1000; i4 = 4'hC;
        @(negedge clk);
        chk("ar_post_gnt", gnt, 4'b1000);
        @(posedge clk);
        #1;
        chk("ar_post_src", out_src, 3);
        chk("ar_post_data", out_data, 4'hC);
        req = 4'b0000;
        @(posedge clk);
        #1;
        chk("ar_drain", out_valid, 0);

        // Random soak: requesters honour the hold-until-granted contract.
        m_v = 1'b0; m_ptr = 0; pend = '0;
        for (int i = 0; i < 4; i++) begin pdata[i] = '0; waitc[i] = 0; end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < 4; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdata[i] = 4'($urandom);
                    waitc[i] = 0;
                end
            req = pend; i1 = pdata[0]; i2 = pdata[1]; i3 = pdata[2]; i4 = pdata[3];
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            can = !m_v || out_ready;
            fnd = 1'b0; w = 0;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!fnd && req[j]) begin fnd = 1'b1; w = j; end
            end
            exp_g = (can && fnd) ? 4'(1 << w) : 4'b0000;
            chk("soak_gnt", gnt, exp_g);
            chk("soak_valid", out_valid, m_v);
            if (m_v && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL soak_underflow: word delivered with nothing expected");
                end else begin
                    e = sb.pop_front();
                    chk("soak_data", out_data, e.d);
                    chk("soak_src", out_src, e.s);
                end
            end
            if (can && fnd) begin
                sb.push_back('{1'b1, pdata[w], 2'(w)});
                chk("soak_starve", waitc[w] <= 3, 1);
                for (int i = 0; i < 4; i++) if (pend[i] && i != w) waitc[i]++;
                pend[w] = 1'b0;
                m_v = 1'b1;
                m_ptr = (w + 1) % 4;
            end else if (m_v && out_ready) m_v = 1'b0;
            @(posedge clk);
            #1;
        end
        if (m_v) begin
            out_ready = 1'b1; req = '0;
            @(negedge clk);
            e = sb.pop_front();
            chk("soak_final_data", out_data, e.d);
            chk("soak_final_src", out_src, e.s);
        end
        chk("soak_queue_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and output register that shares one 4:1 mux path (4 sources, 2-bit select) among four requesters.
- Each requester presents req plus a data word. The block picks one requester, drives the mux select and captures the selected word into a single output slot.
- The slot is drained through a valid/ready handshake.
- Sits between the four producer blocks and the shared downstream consumer.

Parameters:
- DW, 4, width of each requester data word and of out_data.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request bit per requester, index 0..3.
- i1  input  DW  requester 0 data.
- i2  input  DW  requester 1 data.
- i3  input  DW  requester 2 data.
- i4  input  DW  requester 3 data.
- gnt  output  4  one-hot grant, combinational; the asserted bit marks the requester whose data is captured at this clock edge.
- out_valid  output  1  output slot holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  DW  captured word, registered.
- out_src  output  2  index of the requester that supplied out_data (the mux select), registered.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
  - gnt=0 while rst_n is low.
  - Reset mid-transfer drops the held word; no grant is issued during reset.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = EMPTY, or (FULL and out_ready).
  - Drain and refill happen in the same cycle, giving one transfer per cycle when out_ready is held high.
- Arbitration when can_load and req!=0:
  - Winner w is the first index with req[w]=1, searching ptr, ptr+1, ... mod 4.
  - gnt = 1<<w in the same cycle (combinational).
  - At the edge: out_data <= data of w, out_src <= w, out_valid <= 1, ptr <= (w+1) mod 4.
- When can_load=0 or req==0: gnt=0.
  - FULL and not out_ready: hold out_data, out_src, out_valid and ptr unchanged.
  - FULL and out_ready with req==0: go to EMPTY, out_valid <= 0 at the edge. out_data and out_src keep their last value.
  - EMPTY with req==0: stay EMPTY.
- Requester contract:
  - A requester holds req=1 and stable data until it sees its gnt bit high at a clock edge.
  - It may deassert req in the following cycle.
  - The arbiter does not check this contract.
- Latency: req seen with the slot empty at cycle n gives gnt in cycle n and out_valid=1 in cycle n+1.
- Fairness: a continuously requesting requester is granted within 4 loads. ptr advances only on a grant.
- ptr wraps 3 -> 0.
- Simultaneous events:
  - A drain and a new load in the same cycle are a single edge update. out_valid stays 1 and out_data and out_src take the new winner.
  - A req change while FULL-stalled does not alter the held word.
- out_data width is exactly DW. Data is passed without modification.
- Never assert more than one gnt bit. Never assert gnt when can_load=0.

Test Plan:
- Reset then single request: rst_n low 3 cycles, release; req=4'b0100, i3=4'hA, out_ready=1 -> gnt=4'b0100 in that cycle; next cycle out_valid=1, out_data=4'hA, out_src=2; ptr=3.
- Round robin under full load: req=4'b1111 held, data i1..i4 = 1,2,3,4, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1, one gnt bit per cycle.
- Backpressure: FULL with out_src=1, out_ready=0 for 5 cycles while req=4'b1101 -> gnt=0, out_data and out_src frozen; on out_ready=1, the same-cycle grant goes to index 2 (ptr=2) and out_src=2 next cycle.
- Drain to empty: FULL, out_ready=1, req=0 -> out_valid=0 next cycle, gnt=0; a later req=4'b0001 loads again.
- Async reset mid-operation: FULL with out_data=4'h7, out_ready=0, pull rst_n low between edges -> out_valid=0, out_data=0, out_src=0 immediately. After release, req=4'b1000 yields out_src=3, proving ptr restarted at 0 and scanned up to 3.
- Random soak: random req, data and out_ready for 1000 cycles against a reference model -> every word delivered once, in grant order, with out_src matching the granted index and no starvation beyond 4 loads.
